arq_ack_transmitter: RTL and testbench
======================================

Name: arq_ack_transmitter

Overview:
Sits between arq_receiver's ack request interface (p / trigger / did_trigger) and the lossy ack link toward arq_sender. It turns ack triggers into a valid/ready ack stream. Newer cumulative acks coalesce over older unsent ones. Because acks can be lost on the link, it re-sends the last ack on a bounded refresh timer, but only while the receiver reports data in flight, so an idle link carries no ack traffic.

Parameters:
REFRESH_CYCLES, 16, idle cycles after an ack handshake before the last ack is re-sent (>= 2)
MAX_REPEATS, 3, consecutive refresh re-sends allowed without a new trigger; 0 disables refresh

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
trigger  in  1  receiver requests an ack with payload p
p  in  $bits(arq_receiver_pkg::ack)  ack payload (cumulative seq plus flags), sampled when trigger=1
did_trigger  out  1  one-cycle pulse: a triggered (non-refresh) ack completed its handshake
link_active  in  1  receiver has unacknowledged data possible; refresh is enabled only while this is high
out_valid  out  1  ack stream valid
out_ready  in  1  ack stream ready (link accepted the ack)
out_payload  out  $bits(arq_receiver_pkg::ack)  ack stream payload

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE; out_valid=0; did_trigger=0; out_payload='0; pending=0; repeat_cnt=0; timer=0; has_sent=0. A reset in the middle of a handshake drops the in-flight ack and the pending ack. No pulse occurs in the cycle after reset.
- Storage: one output register (out_payload, plus a flag is_refresh), one pending slot (pend_p, pending), and a last_sent register.
- States: IDLE, SEND, WAIT_REFRESH.
- IDLE:
  - trigger -> SEND next cycle; out_payload=p; is_refresh=0. Latency trigger->out_valid is 1 cycle.
- SEND (out_valid=1):
  - out_payload and out_valid are held stable while out_ready=0.
  - trigger while not handshaking -> pend_p=p, pending=1. A later trigger overwrites the slot (latest wins).
  - On handshake (out_valid && out_ready):
    - last_sent <= out_payload; has_sent=1.
    - did_trigger=1 in the same cycle if is_refresh=0.
    - Next state, by priority:
      - trigger in the same cycle -> SEND with p; repeat_cnt=0.
      - else pending -> SEND with pend_p; pending=0; repeat_cnt=0.
      - else link_active && repeat_cnt<MAX_REPEATS -> WAIT_REFRESH; timer=REFRESH_CYCLES-1.
      - else -> IDLE.
  - Back-to-back acks are sustained at 1 per cycle while out_ready=1.
- WAIT_REFRESH:
  - trigger -> SEND with p; repeat_cnt=0. This has priority over timer expiry.
  - else !link_active -> IDLE; repeat_cnt=0.
  - else timer==0 -> SEND with last_sent; is_refresh=1; repeat_cnt+1 (saturating).
  - else timer-1.
- did_trigger pulses once per sent triggered ack, not once per trigger. Coalesced triggers get no individual pulse. It is never high when out_valid was low in that cycle.
- No out_valid without a prior trigger since reset (has_sent gates refresh).
- Once link_active=0 and trigger=0, out_valid deasserts within 1 cycle after any outstanding handshake completes. The ack link then stays quiet.
- timer width: $clog2(REFRESH_CYCLES). repeat_cnt width: $clog2(MAX_REPEATS+1), minimum 1.

Decomposition:
- ack typedef and its field layout come from arq_receiver_pkg, reused unchanged.
- Add state_t (IDLE/SEND/WAIT_REFRESH) in a small arq_ack_transmitter_pkg.
- Natural sub-module: arq_ack_refresh_timer. It owns the load, count-down, expiry, repeat_cnt and saturation logic. Its inputs are load, clear and link_active; its outputs are expire and exhausted.
- Formal: add arq_ack_transmitter between receiver and ack_link in arq_formal. The existing no_unneccessary_traffic_ack assertion is then re-targeted to out_valid.

Test Plan:
- Single ack: trigger=1 for one cycle with p=seq 5, out_ready=1 -> out_valid=1 at t+1 with payload 5; did_trigger pulse at t+1; state goes to WAIT_REFRESH if link_active=1.
- Backpressure coalescing: out_ready=0; triggers with seq 1, 2, 3 on consecutive cycles -> out_payload stays 1. On out_ready=1: handshake 1 with a did_trigger pulse, then the next cycle sends 3 with a did_trigger pulse; 2 is never sent.
- Refresh: after an ack with seq 7, link_active=1, no triggers, out_ready=1 -> seq 7 is re-sent 16 cycles after each handshake, exactly 3 times, with no did_trigger pulses; then IDLE with silence.
- Refresh cancel: link_active drops 5 cycles into WAIT_REFRESH -> IDLE next cycle; no further out_valid.
- Trigger vs expiry: trigger with seq 9 in the same cycle the timer hits 0 -> seq 9 is sent (is_refresh=0, did_trigger pulses); repeat_cnt resets to 0.
- Reset mid-stall: out_valid=1, out_ready=0, pending=1, then rst for 1 cycle -> out_valid=0 and did_trigger=0 from the next cycle; no refresh until a new trigger.

Source files
------------

// File: rtl/arq_ack_transmitter_pkg.sv
// rtl/arq_ack_transmitter_pkg.sv - state encoding and widths for the ack transmitter
package arq_ack_transmitter_pkg;

    localparam int ACK_W = $bits(arq_receiver_pkg::ack);

    typedef logic [1:0] state_t;

    localparam state_t IDLE         = 2'd0;
    localparam state_t SEND         = 2'd1;
    localparam state_t WAIT_REFRESH = 2'd2;

endpackage

// File: rtl/arq_receiver_pkg.sv
// rtl/arq_receiver_pkg.sv - ack payload layout shared with the receiver
package arq_receiver_pkg;

    localparam int SEQ_W = 8;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic             fin;
        logic             nack;
    } ack;

endpackage

// File: rtl/arq_ack_refresh_timer.sv
// rtl/arq_ack_refresh_timer.sv - refresh countdown and bounded repeat counter
module arq_ack_refresh_timer #(
    parameter int REFRESH_CYCLES = 16,
    parameter int MAX_REPEATS    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic link_active,
    output logic expire,
    output logic exhausted
);

    localparam int TW = $clog2(REFRESH_CYCLES);
    localparam int CW = (MAX_REPEATS > 0) ? $clog2(MAX_REPEATS + 1) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] CMAX  = CW'(MAX_REPEATS);

    logic [TW-1:0] timer;
    logic [CW-1:0] repeat_cnt;
    logic          armed;

    // armed tracks whether a countdown is live; it drops on expiry, clear or link idle
    assign expire    = armed && link_active && (timer == '0);
    assign exhausted = (repeat_cnt >= CMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            repeat_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (clear) begin
                repeat_cnt <= '0;
            end else if (expire && (repeat_cnt != CMAX)) begin
                repeat_cnt <= repeat_cnt + CW'(1);
            end

            if (load) begin
                armed <= 1'b1;
                timer <= TLOAD;
            end else if (clear || !link_active || expire) begin
                armed <= 1'b0;
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end
        end
    end

endmodule

// File: rtl/arq_ack_transmitter.sv
// rtl/arq_ack_transmitter.sv - coalescing ack stream source with bounded refresh
module arq_ack_transmitter
    import arq_ack_transmitter_pkg::*;
#(
    parameter int REFRESH_CYCLES = 16,
    parameter int MAX_REPEATS    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [ACK_W-1:0] p,
    output logic             did_trigger,
    input  logic             link_active,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACK_W-1:0] out_payload
);

    state_t           state;
    logic             is_refresh;
    logic             pending;
    logic             has_sent;
    logic [ACK_W-1:0] pend_p;
    logic [ACK_W-1:0] last_sent;

    logic hs;
    logic load;
    logic clear;
    logic expire;
    logic exhausted;

    assign out_valid   = (state == SEND);
    assign hs          = out_valid && out_ready;
    assign did_trigger = hs && !is_refresh;

    // Any fresh trigger restarts the repeat budget; the timer arms only when nothing newer is queued
    assign load  = hs && !trigger && !pending && link_active && !exhausted;
    assign clear = trigger || (hs && pending) || ((state == WAIT_REFRESH) && !link_active);

    arq_ack_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES),
        .MAX_REPEATS    (MAX_REPEATS)
    ) u_refresh_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .clear       (clear),
        .link_active (link_active),
        .expire      (expire),
        .exhausted   (exhausted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_payload <= '0;
            is_refresh  <= 1'b0;
            pending     <= 1'b0;
            pend_p      <= '0;
            last_sent   <= '0;
            has_sent    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state       <= SEND;
                        out_payload <= p;
                        is_refresh  <= 1'b0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        last_sent <= out_payload;
                        has_sent  <= 1'b1;
                        // A same-cycle trigger is newer than the slot, so the slot is dropped
                        if (trigger) begin
                            out_payload <= p;
                            is_refresh  <= 1'b0;
                            pending     <= 1'b0;
                        end else if (pending) begin
                            out_payload <= pend_p;
                            is_refresh  <= 1'b0;
                            pending     <= 1'b0;
                        end else if (load) begin
                            state <= WAIT_REFRESH;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (trigger) begin
                        pend_p  <= p;
                        pending <= 1'b1;
                    end
                end
                WAIT_REFRESH: begin
                    if (trigger) begin
                        state       <= SEND;
                        out_payload <= p;
                        is_refresh  <= 1'b0;
                    end else if (!link_active) begin
                        state <= IDLE;
                    end else if (expire && has_sent) begin
                        state       <= SEND;
                        out_payload <= last_sent;
                        is_refresh  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arq_ack_transmitter.sv
// tb/tb_arq_ack_transmitter.sv - randomized and directed checks against a behavioural ack model
module tb_arq_ack_transmitter;
    import arq_ack_transmitter_pkg::*;

    localparam int RC = 16;
    localparam int MR = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             trigger;
    logic [ACK_W-1:0] p;
    logic             did_trigger;
    logic             link_active;
    logic             out_valid;
    logic             out_ready;
    logic [ACK_W-1:0] out_payload;

    always #5 clk = ~clk;

    arq_ack_transmitter #(
        .REFRESH_CYCLES (RC),
        .MAX_REPEATS    (MR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .p           (p),
        .did_trigger (did_trigger),
        .link_active (link_active),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural view: an ack on offer, an optional newer ack waiting, and an idle-cycle countdown
    bit               m_known = 0;
    bit               m_offering;
    bit               m_refresh;
    logic [ACK_W-1:0] m_offer;
    bit               m_have_pend;
    logic [ACK_W-1:0] m_pend;
    logic [ACK_W-1:0] m_last;
    bit               m_waiting;
    int               m_idle_left;
    int               m_refreshes;

    logic [ACK_W-1:0] hs_q[$];
    int               obs_dt;
    int               obs_ref;

    function automatic logic [ACK_W-1:0] mk(input int s);
        return {8'(s), 2'b00};
    endfunction

    task automatic model_update(input logic t, input logic [ACK_W-1:0] pv, input logic rdy,
                                input logic la, input logic r);
        if (r) begin
            m_known     = 1;
            m_offering  = 0;
            m_refresh   = 0;
            m_have_pend = 0;
            m_waiting   = 0;
            m_refreshes = 0;
        end else if (m_known) begin
            if (m_offering) begin
                if (rdy) begin
                    m_last = m_offer;
                    if (t) begin
                        m_offer = pv; m_refresh = 0; m_refreshes = 0; m_have_pend = 0;
                    end else if (m_have_pend) begin
                        m_offer = m_pend; m_refresh = 0; m_refreshes = 0; m_have_pend = 0;
                    end else begin
                        m_offering = 0;
                        if (la && m_refreshes < MR) begin
                            m_waiting   = 1;
                            m_idle_left = RC;
                        end
                    end
                end else if (t) begin
                    m_have_pend = 1; m_pend = pv; m_refreshes = 0;
                end
            end else if (m_waiting) begin
                if (t) begin
                    m_waiting = 0; m_offering = 1; m_offer = pv; m_refresh = 0; m_refreshes = 0;
                end else if (!la) begin
                    m_waiting = 0; m_refreshes = 0;
                end else if (m_idle_left == 1) begin
                    m_waiting = 0; m_offering = 1; m_offer = m_last; m_refresh = 1;
                    m_refreshes++;
                end else begin
                    m_idle_left--;
                end
            end else if (t) begin
                m_offering = 1; m_offer = pv; m_refresh = 0; m_refreshes = 0;
            end
        end
    endtask

    task automatic step(input logic t, input logic [ACK_W-1:0] pv, input logic rdy,
                        input logic la, input logic r);
        trigger     = t;
        p           = pv;
        out_ready   = rdy;
        link_active = la;
        rst         = r;
        @(negedge clk);
        if (m_known) begin
            check("out_valid", 32'(out_valid), 32'(m_offering));
            if (m_offering) check("out_payload", 32'(out_payload), 32'(m_offer));
            check("did_trigger", 32'(did_trigger), 32'(m_offering && rdy && !m_refresh));
        end
        if (out_valid && out_ready) begin
            hs_q.push_back(out_payload);
            if (!did_trigger) obs_ref++;
        end
        if (did_trigger) obs_dt++;
        @(posedge clk);
        model_update(t, pv, rdy, la, r);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy, input logic la);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, la, 1'b0);
    endtask

    task automatic clr_obs();
        hs_q.delete();
        obs_dt  = 0;
        obs_ref = 0;
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        clr_obs();
    endtask

    initial begin
        logic la_r;
        rst = 1'b1; trigger = 1'b0; p = '0; out_ready = 1'b0; link_active = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        do_reset();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_payload", 32'(out_payload), 32'd0);
        check("reset_did_trigger", 32'(did_trigger), 32'd0);

        // single ack followed by the full refresh sequence
        do_reset();
        step(1'b1, mk(7), 1'b1, 1'b1, 1'b0);
        idle(80, 1'b1, 1'b1);
        check("refresh_hs_count", 32'(hs_q.size()), 32'd4);
        check("refresh_resends", 32'(obs_ref), 32'd3);
        check("refresh_dt_count", 32'(obs_dt), 32'd1);
        foreach (hs_q[i]) check("refresh_payload", 32'(hs_q[i]), 32'(mk(7)));
        check("refresh_quiet", 32'(out_valid), 32'd0);

        // backpressure coalescing
        do_reset();
        step(1'b1, mk(1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(2), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(3), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        idle(5, 1'b1, 1'b0);
        check("coalesce_count", 32'(hs_q.size()), 32'd2);
        if (hs_q.size() == 2) begin
            check("coalesce_first", 32'(hs_q[0]), 32'(mk(1)));
            check("coalesce_second", 32'(hs_q[1]), 32'(mk(3)));
        end
        check("coalesce_dt", 32'(obs_dt), 32'd2);

        // refresh cancelled by the link going idle
        do_reset();
        step(1'b1, mk(4), 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1, 1'b1);
        idle(30, 1'b1, 1'b0);
        check("cancel_hs_count", 32'(hs_q.size()), 32'd1);

        // trigger in the same cycle as timer expiry
        do_reset();
        step(1'b1, mk(8), 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(RC - 1, 1'b1, 1'b1);
        step(1'b1, mk(9), 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("expiry_trig_count", 32'(hs_q.size()), 32'd2);
        if (hs_q.size() == 2) check("expiry_trig_payload", 32'(hs_q[1]), 32'(mk(9)));
        check("expiry_trig_dt", 32'(obs_dt), 32'd2);
        idle(60, 1'b1, 1'b1);
        check("expiry_refreshes", 32'(obs_ref), 32'd3);

        // reset while stalled with a pending ack
        do_reset();
        step(1'b1, mk(1), 1'b0, 1'b1, 1'b0);
        step(1'b1, mk(2), 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        clr_obs();
        idle(40, 1'b1, 1'b1);
        check("stall_reset_hs", 32'(hs_q.size()), 32'd0);
        check("stall_reset_dt", 32'(obs_dt), 32'd0);

        // randomized traffic
        la_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) la_r = ~la_r;
            step(($urandom_range(0, 5) == 0), ACK_W'($urandom), ($urandom_range(0, 3) != 0),
                 la_r, ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
